// File: rtl/commit_regfile_mp.sv
// Multi-port commit-stage register file: NR bypassed read ports, NW program-ordered
// write slots, retired-instruction counter and registered difftest snapshot.
module commit_regfile_mp #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned NR   = 4,
    parameter int unsigned NW   = 2,
    parameter int unsigned CW   = 64,
    localparam int unsigned AW   = $clog2(NREG),
    localparam int unsigned CNTW = $clog2(NW + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NR*AW-1:0]     io_rd_addr,
    output logic [NR*XLEN-1:0]   io_rd_data,
    input  logic [NW-1:0]        io_wb_valid,
    input  logic [NW*AW-1:0]     io_wb_addr,
    input  logic [NW*XLEN-1:0]   io_wb_data,
    input  logic [NW-1:0]        io_commit_valid,
    input  logic [NW*XLEN-1:0]   io_commit_pc,
    input  logic [NW*32-1:0]     io_commit_inst,
    input  logic                 io_irq,
    input  logic                 io_peripheral,
    output logic                 io_dt_commit,
    output logic [CNTW-1:0]      io_dt_count,
    output logic [XLEN-1:0]      io_dt_pc,
    output logic [31:0]          io_dt_inst,
    output logic                 io_dt_irq,
    output logic                 io_dt_peripheral,
    output logic [CW-1:0]        io_inst_counter
);

    // Architectural state, index = register number (difftest hook reads this array).
    logic [XLEN-1:0] regs [NREG];

    logic [AW-1:0]   rd_a;
    logic [XLEN-1:0] rd_v;
    logic [CNTW-1:0] retire_cnt;
    logic            retire_any;
    logic [XLEN-1:0] young_pc;
    logic [31:0]     young_inst;

    // Read ports: later slots override earlier ones so the youngest writer is forwarded.
    always_comb begin
        io_rd_data = '0;
        rd_a       = '0;
        rd_v       = '0;
        for (int i = 0; i < int'(NR); i++) begin
            rd_a = io_rd_addr[i*AW +: AW];
            rd_v = regs[rd_a];
            for (int k = 0; k < int'(NW); k++) begin
                if (io_wb_valid[k] && (io_wb_addr[k*AW +: AW] == rd_a)) begin
                    rd_v = io_wb_data[k*XLEN +: XLEN];
                end
            end
            if (reset || (rd_a == '0)) begin
                rd_v = '0;
            end
            io_rd_data[i*XLEN +: XLEN] = rd_v;
        end
    end

    // Retirement summary: count and youngest valid slot (slots may be non-contiguous).
    always_comb begin
        retire_cnt = '0;
        retire_any = 1'b0;
        young_pc   = '0;
        young_inst = '0;
        for (int k = 0; k < int'(NW); k++) begin
            if (io_commit_valid[k]) begin
                retire_cnt = retire_cnt + CNTW'(1);
                retire_any = 1'b1;
                young_pc   = io_commit_pc[k*XLEN +: XLEN];
                young_inst = io_commit_inst[k*32 +: 32];
            end
        end
    end

    // Register writes: ascending slot order makes the highest-index slot win a collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NW); k++) begin
                if (io_wb_valid[k] && (io_wb_addr[k*AW +: AW] != '0)) begin
                    regs[io_wb_addr[k*AW +: AW]] <= io_wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Counter and difftest snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_inst_counter  <= '0;
            io_dt_commit     <= 1'b0;
            io_dt_count      <= '0;
            io_dt_pc         <= '0;
            io_dt_inst       <= '0;
            io_dt_irq        <= 1'b0;
            io_dt_peripheral <= 1'b0;
        end else begin
            io_inst_counter  <= io_inst_counter + CW'(retire_cnt);
            io_dt_commit     <= retire_any;
            io_dt_count      <= retire_cnt;
            io_dt_irq        <= io_irq;
            io_dt_peripheral <= io_peripheral;
            if (retire_any) begin
                io_dt_pc   <= young_pc;
                io_dt_inst <= young_inst;
            end
        end
    end

endmodule

// File: tb/tb_commit_regfile_mp.sv
// Directed self-checking bench for commit_regfile_mp (CW=8 to exercise counter wrap).
module tb_commit_regfile_mp;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned NR   = 4;
    localparam int unsigned NW   = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned AW   = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NR*AW-1:0]     rd_addr;
    logic [NR*XLEN-1:0]   rd_data;
    logic [NW-1:0]        wb_valid;
    logic [NW*AW-1:0]     wb_addr;
    logic [NW*XLEN-1:0]   wb_data;
    logic [NW-1:0]        commit_valid;
    logic [NW*XLEN-1:0]   commit_pc;
    logic [NW*32-1:0]     commit_inst;
    logic                 irq;
    logic                 peripheral;
    logic                 dt_commit;
    logic [1:0]           dt_count;
    logic [XLEN-1:0]      dt_pc;
    logic [31:0]          dt_inst;
    logic                 dt_irq;
    logic                 dt_peripheral;
    logic [CW-1:0]        inst_counter;

    int errors = 0;
    int checks = 0;

    commit_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW), .CW(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_rd_addr       (rd_addr),
        .io_rd_data       (rd_data),
        .io_wb_valid      (wb_valid),
        .io_wb_addr       (wb_addr),
        .io_wb_data       (wb_data),
        .io_commit_valid  (commit_valid),
        .io_commit_pc     (commit_pc),
        .io_commit_inst   (commit_inst),
        .io_irq           (irq),
        .io_peripheral    (peripheral),
        .io_dt_commit     (dt_commit),
        .io_dt_count      (dt_count),
        .io_dt_pc         (dt_pc),
        .io_dt_inst       (dt_inst),
        .io_dt_irq        (dt_irq),
        .io_dt_peripheral (dt_peripheral),
        .io_inst_counter  (inst_counter)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] port(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                          input logic [4:0] a1, input logic [63:0] d1);
        wb_valid = v;
        wb_addr  = {a1, a0};
        wb_data  = {d1, d0};
    endtask

    task automatic set_commit(input logic [1:0] v, input logic [63:0] pc0, input logic [31:0] i0,
                              input logic [63:0] pc1, input logic [31:0] i1);
        commit_valid = v;
        commit_pc    = {pc1, pc0};
        commit_inst  = {i1, i0};
    endtask

    // Advance one edge, then leave a settling gap before inputs change.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        irq = 1'b0;
        peripheral = 1'b0;
        set_rd(5'd5, 5'd5, 5'd5, 5'd5);
        set_wb(2'b11, 5'd5, 64'hAA, 5'd5, 64'hAA);
        set_commit(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("rst_rd%0d", i), port(i), 64'h0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) check($sformatf("rst2_rd%0d", i), port(i), 64'h0);
        check("rst_counter", 64'(inst_counter), 64'h0);
        check("rst_dt_commit", 64'(dt_commit), 64'h0);
        check("rst_dt_count", 64'(dt_count), 64'h0);
        check("rst_dt_pc", dt_pc, 64'h0);
        check("rst_dt_inst", 64'(dt_inst), 64'h0);
        check("rst_dt_irq", 64'(dt_irq), 64'h0);
        check("rst_dt_periph", 64'(dt_peripheral), 64'h0);

        reset = 1'b0;
        set_wb(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        tick();
        #1 check("x5_after_rst", port(0), 64'h0);

        // Basic write with same-cycle bypass, then array read.
        set_wb(2'b01, 5'd3, 64'h1234, 5'd0, 64'h0);
        set_rd(5'd3, 5'd0, 5'd0, 5'd0);
        #1 check("x3_bypass", port(0), 64'h1234);
        tick();
        set_wb(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1 check("x3_array", port(0), 64'h1234);

        // Collision: slot1 is younger and wins.
        set_wb(2'b11, 5'd7, 64'h11, 5'd7, 64'h22);
        set_rd(5'd7, 5'd7, 5'd7, 5'd7);
        #1 for (int i = 0; i < 4; i++) check($sformatf("x7_bypass%0d", i), port(i), 64'h22);
        tick();
        set_wb(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1 for (int i = 0; i < 4; i++) check($sformatf("x7_array%0d", i), port(i), 64'h22);

        // Bypass is independent of commit_valid; older slot only.
        set_wb(2'b01, 5'd9, 64'h99, 5'd0, 64'h0);
        set_rd(5'd9, 5'd0, 5'd0, 5'd0);
        #1 check("x9_bypass_nocommit", port(0), 64'h99);
        tick();
        set_wb(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);

        // x0 guard.
        set_wb(2'b10, 5'd0, 64'h0, 5'd0, 64'hFFFF);
        set_rd(5'd0, 5'd3, 5'd7, 5'd9);
        #1 check("x0_same", port(0), 64'h0);
        tick();
        set_wb(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1;
        check("x0_next", port(0), 64'h0);
        check("x3_kept", port(1), 64'h1234);
        check("x7_kept", port(2), 64'h22);
        check("x9_kept", port(3), 64'h99);

        // Retire counting and snapshot.
        irq = 1'b1;
        peripheral = 1'b1;
        set_commit(2'b11, 64'h8000_0000, 32'h13, 64'h8000_0004, 32'h93);
        tick();
        check("ret1_counter", 64'(inst_counter), 64'd2);
        check("ret1_pc", dt_pc, 64'h8000_0004);
        check("ret1_inst", 64'(dt_inst), 64'h93);
        check("ret1_count", 64'(dt_count), 64'd2);
        check("ret1_commit", 64'(dt_commit), 64'd1);
        check("ret1_irq", 64'(dt_irq), 64'd1);
        check("ret1_periph", 64'(dt_peripheral), 64'd1);
        irq = 1'b0;
        peripheral = 1'b0;
        set_commit(2'b00, 64'h1111, 32'h1, 64'h2222, 32'h2);
        tick();
        check("ret2_counter", 64'(inst_counter), 64'd2);
        check("ret2_pc_held", dt_pc, 64'h8000_0004);
        check("ret2_inst_held", 64'(dt_inst), 64'h93);
        check("ret2_count", 64'(dt_count), 64'd0);
        check("ret2_commit", 64'(dt_commit), 64'd0);
        check("ret2_irq", 64'(dt_irq), 64'd0);
        set_commit(2'b01, 64'h8000_0008, 32'h33, 64'hDEAD, 32'hBEEF);
        tick();
        check("ret3_counter", 64'(inst_counter), 64'd3);
        check("ret3_pc", dt_pc, 64'h8000_0008);
        check("ret3_count", 64'(dt_count), 64'd1);
        set_commit(2'b10, 64'h1, 32'h1, 64'h8000_000C, 32'h73);
        tick();
        check("ret4_counter", 64'(inst_counter), 64'd4);
        check("ret4_pc", dt_pc, 64'h8000_000C);
        check("ret4_inst", 64'(dt_inst), 64'h73);
        check("ret4_count", 64'(dt_count), 64'd1);

        // Mid-operation reset drops pending write and clears counter.
        reset = 1'b1;
        set_wb(2'b01, 5'd4, 64'h44, 5'd0, 64'h0);
        set_commit(2'b11, 64'h0, 32'h0, 64'h0, 32'h0);
        tick();
        reset = 1'b0;
        set_wb(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        set_commit(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
        set_rd(5'd4, 5'd3, 5'd0, 5'd0);
        #1;
        check("mid_rst_counter", 64'(inst_counter), 64'd0);
        check("mid_rst_x4", port(0), 64'h0);
        check("mid_rst_x3", port(1), 64'h0);

        // Counter wrap at CW=8.
        set_commit(2'b11, 64'h100, 32'h1, 64'h104, 32'h2);
        repeat (127) tick();
        set_commit(2'b01, 64'h108, 32'h3, 64'h0, 32'h0);
        tick();
        check("wrap_preload", 64'(inst_counter), 64'd255);
        set_commit(2'b11, 64'h10C, 32'h4, 64'h110, 32'h5);
        tick();
        check("wrap_result", 64'(inst_counter), 64'd1);
        check("wrap_pc", dt_pc, 64'h110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
